// File: rtl/spectrum_peak_detector.sv
// Purpose: per-frame peak search over a float32 |X|^2 bin stream (value, index, length, status).
// Latency: one registered result pulse in the cycle after power_data_last; next frame may start at once.
// Backpressure: none, one sample accepted every cycle; optional PEAK_NEIGHBOURS_EN adds peak_left/peak_right.
module spectrum_peak_detector #(
    parameter int IDX_W     = 12,
    parameter int MAX_BINS  = 4096,
    parameter int SKIP_BINS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      power_data,
    input  logic             power_data_en,
    input  logic             power_data_last,
    output logic             peak_valid,
    output logic [31:0]      peak_value,
    output logic [IDX_W-1:0] peak_index,
    output logic [IDX_W:0]   frame_len,
    output logic             peak_found,
    output logic             frame_overflow
`ifdef PEAK_NEIGHBOURS_EN
    ,
    output logic [31:0]      peak_left,
    output logic [31:0]      peak_right
`endif
);

    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BINS);

    // Running search state for the open frame
    logic [CW-1:0]    bin_cnt;
    logic [30:0]      max_val;
    logic [IDX_W-1:0] max_idx;
    logic             cand;
    logic             ovf;

    // Next-state values, including the sample presented this cycle
    logic [CW-1:0]    cnt_nxt;
    logic [30:0]      max_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             cand_nxt;
    logic             ovf_nxt;

    logic in_range;
    logic accept;
    logic is_nan;
    logic skip_ok;
    logic eligible;
    logic update;

    // Leading DC bins are excluded; a zero skip count removes the comparison entirely
    generate
        if (SKIP_BINS == 0) begin : g_no_skip
            assign skip_ok = 1'b1;
        end else begin : g_skip
            localparam logic [CW-1:0] SKIP_C = CW'(SKIP_BINS);
            assign skip_ok = (bin_cnt >= SKIP_C);
        end
    endgenerate

    assign in_range = (bin_cnt < MAX_C);
    assign accept   = power_data_en && in_range;
    assign is_nan   = (&power_data[30:23]) && (|power_data[22:0]);
    assign eligible = accept && skip_ok && !power_data[31] && !is_nan;
    // Non-negative floats order correctly as unsigned magnitude bits; strict > keeps the earliest tie
    assign update   = eligible && (!cand || (power_data[30:0] > max_val));

    // Fold the current sample into the search state
    always_comb begin
        cnt_nxt  = accept ? (bin_cnt + CW'(1)) : bin_cnt;
        ovf_nxt  = ovf | (power_data_en && !in_range);
        max_nxt  = update ? power_data[30:0] : max_val;
        idx_nxt  = update ? bin_cnt[IDX_W-1:0] : max_idx;
        cand_nxt = cand | update;
    end

`ifdef PEAK_NEIGHBOURS_EN
    logic [31:0] prev_dat;
    logic [31:0] left_r;
    logic [31:0] right_r;
    logic        right_pend;
    logic [31:0] left_nxt;
    logic [31:0] right_nxt;
    logic        pend_nxt;

    // Track the raw samples either side of the current peak
    always_comb begin
        left_nxt  = left_r;
        right_nxt = right_r;
        pend_nxt  = right_pend;
        if (update) begin
            left_nxt  = (bin_cnt == '0) ? 32'd0 : prev_dat;
            right_nxt = 32'd0;
            pend_nxt  = 1'b1;
        end else if (right_pend && accept) begin
            right_nxt = power_data;
            pend_nxt  = 1'b0;
        end
    end

    // Neighbour working registers, re-armed at frame end like the search state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dat   <= 32'd0;
            left_r     <= 32'd0;
            right_r    <= 32'd0;
            right_pend <= 1'b0;
        end else begin
            if (accept) begin
                prev_dat <= power_data;
            end
            if (power_data_last) begin
                left_r     <= 32'd0;
                right_r    <= 32'd0;
                right_pend <= 1'b0;
            end else begin
                left_r     <= left_nxt;
                right_r    <= right_nxt;
                right_pend <= pend_nxt;
            end
        end
    end

    // Neighbour outputs latch together with the peak value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_left  <= 32'd0;
            peak_right <= 32'd0;
        end else if (power_data_last) begin
            peak_left  <= left_nxt;
            peak_right <= right_nxt;
        end
    end
`endif

    // Search state: advance per sample, re-arm in the frame-end cycle so the next cycle is bin 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
            max_val <= '0;
            max_idx <= '0;
            cand    <= 1'b0;
            ovf     <= 1'b0;
        end else if (power_data_last) begin
            bin_cnt <= '0;
            max_val <= '0;
            max_idx <= '0;
            cand    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            bin_cnt <= cnt_nxt;
            max_val <= max_nxt;
            max_idx <= idx_nxt;
            cand    <= cand_nxt;
            ovf     <= ovf_nxt;
        end
    end

    // Result registers: one-cycle valid pulse, fields held until the next frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_valid     <= 1'b0;
            peak_value     <= 32'd0;
            peak_index     <= '0;
            frame_len      <= '0;
            peak_found     <= 1'b0;
            frame_overflow <= 1'b0;
        end else begin
            peak_valid <= power_data_last;
            if (power_data_last) begin
                peak_value     <= {1'b0, max_nxt};
                peak_index     <= idx_nxt;
                frame_len      <= cnt_nxt;
                peak_found     <= cand_nxt;
                frame_overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Directed bench: two instances share one stimulus stream.
// dut_a uses default parameters (SKIP_BINS=1, MAX_BINS=4096); dut_b uses SKIP_BINS=0, MAX_BINS=8.
// Each scenario task checks packed result vectors of both instances against hand-computed values.
module tb_spectrum_peak_detector;

    logic        clk;
    logic        rst_n;
    logic [31:0] pd;
    logic        en;
    logic        last;

    logic        a_valid, a_found, a_ovf;
    logic [31:0] a_val;
    logic [11:0] a_idx;
    logic [12:0] a_len;

    logic        b_valid, b_found, b_ovf;
    logic [31:0] b_val;
    logic [3:0]  b_idx;
    logic [4:0]  b_len;

`ifdef PEAK_NEIGHBOURS_EN
    logic [31:0] a_left, a_right, b_left, b_right;
`endif

    int compared;
    int mismatched;

    // {valid, found, overflow, index, len, value}
    logic [59:0] obs_a;
    logic [43:0] obs_b;
    assign obs_a = {a_valid, a_found, a_ovf, a_idx, a_len, a_val};
    assign obs_b = {b_valid, b_found, b_ovf, b_idx, b_len, b_val};

    spectrum_peak_detector dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .power_data      (pd),
        .power_data_en   (en),
        .power_data_last (last),
        .peak_valid      (a_valid),
        .peak_value      (a_val),
        .peak_index      (a_idx),
        .frame_len       (a_len),
        .peak_found      (a_found),
        .frame_overflow  (a_ovf)
`ifdef PEAK_NEIGHBOURS_EN
        ,
        .peak_left       (a_left),
        .peak_right      (a_right)
`endif
    );

    spectrum_peak_detector #(.IDX_W(4), .MAX_BINS(8), .SKIP_BINS(0)) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .power_data      (pd),
        .power_data_en   (en),
        .power_data_last (last),
        .peak_valid      (b_valid),
        .peak_value      (b_val),
        .peak_index      (b_idx),
        .frame_len       (b_len),
        .peak_found      (b_found),
        .frame_overflow  (b_ovf)
`ifdef PEAK_NEIGHBOURS_EN
        ,
        .peak_left       (b_left),
        .peak_right      (b_right)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sample/last per cycle; returns 1 time unit after the capturing edge
    task automatic drive(input logic e, input logic [31:0] d, input logic l);
        en   = e;
        pd   = d;
        last = l;
        @(posedge clk);
        #1;
        en   = 1'b0;
        last = 1'b0;
        pd   = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        last  = 1'b0;
        pd    = 32'd0;
        #3;
        compared++;
        if (obs_a !== 60'd0) begin
            mismatched++;
            $display("FAIL reset_a: got %h want %h", obs_a, 60'd0);
        end
        compared++;
        if (obs_b !== 44'd0) begin
            mismatched++;
            $display("FAIL reset_b: got %h want %h", obs_b, 44'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_dc_skip;
        drive(1'b1, 32'h40800000, 1'b0);
        drive(1'b1, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40000000, 1'b0);
        drive(1'b1, 32'h3F000000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd2, 13'd4, 32'h40000000}) begin
            mismatched++;
            $display("FAIL dc_skip_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd2, 13'd4, 32'h40000000});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd0, 5'd4, 32'h40800000}) begin
            mismatched++;
            $display("FAIL dc_skip_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd0, 5'd4, 32'h40800000});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'h3F800000, 32'h3F000000, 32'h0, 32'h3F800000}) begin
            mismatched++;
            $display("FAIL dc_skip_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
    endtask

    task automatic test_tie;
        drive(1'b1, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40000000, 1'b0);
        drive(1'b1, 32'h40000000, 1'b0);
        drive(1'b1, 32'h3F800000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd1, 13'd4, 32'h40000000}) begin
            mismatched++;
            $display("FAIL tie_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd1, 13'd4, 32'h40000000});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd1, 5'd4, 32'h40000000}) begin
            mismatched++;
            $display("FAIL tie_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd1, 5'd4, 32'h40000000});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000}) begin
            mismatched++;
            $display("FAIL tie_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
    endtask

    task automatic test_nan_negative;
        drive(1'b1, 32'h3E800000, 1'b0);
        drive(1'b1, 32'h7FC00000, 1'b0);
        drive(1'b1, 32'hC0800000, 1'b0);
        drive(1'b1, 32'h3F800000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd3, 13'd4, 32'h3F800000}) begin
            mismatched++;
            $display("FAIL nan_neg_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd3, 13'd4, 32'h3F800000});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd3, 5'd4, 32'h3F800000}) begin
            mismatched++;
            $display("FAIL nan_neg_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd3, 5'd4, 32'h3F800000});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'hC0800000, 32'h0, 32'hC0800000, 32'h0}) begin
            mismatched++;
            $display("FAIL nan_neg_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
    endtask

    // last with en=0 right after the previous frame's last
    task automatic test_empty_frame;
        drive(1'b0, 32'h0, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 12'd0, 13'd0, 32'h0}) begin
            mismatched++;
            $display("FAIL empty_a: got %h want %h", obs_a, {1'b1, 1'b0, 1'b0, 12'd0, 13'd0, 32'h0});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0}) begin
            mismatched++;
            $display("FAIL empty_b: got %h want %h", obs_b, {1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0});
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40000000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL b2b_first_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL b2b_first_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'h3F800000, 32'h0, 32'h3F800000, 32'h0}) begin
            mismatched++;
            $display("FAIL b2b_first_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
        // Sample in T+1 belongs to the next frame; fields must hold with valid low
        drive(1'b1, 32'h40400000, 1'b0);
        compared++;
        if (obs_a !== {1'b0, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL b2b_hold_a: got %h want %h", obs_a, {1'b0, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000});
        end
        compared++;
        if (obs_b !== {1'b0, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL b2b_hold_b: got %h want %h", obs_b, {1'b0, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000});
        end
        drive(1'b0, 32'h0, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 12'd0, 13'd1, 32'h0}) begin
            mismatched++;
            $display("FAIL b2b_second_a: got %h want %h", obs_a, {1'b1, 1'b0, 1'b0, 12'd0, 13'd1, 32'h0});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd0, 5'd1, 32'h40400000}) begin
            mismatched++;
            $display("FAIL b2b_second_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd0, 5'd1, 32'h40400000});
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h3F800000 + 32'(i), (i == 9));
        end
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd9, 13'd10, 32'h3F800009}) begin
            mismatched++;
            $display("FAIL ovf_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd9, 13'd10, 32'h3F800009});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b1, 4'd7, 5'd8, 32'h3F800007}) begin
            mismatched++;
            $display("FAIL ovf_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b1, 4'd7, 5'd8, 32'h3F800007});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'h3F800008, 32'h0, 32'h3F800006, 32'h0}) begin
            mismatched++;
            $display("FAIL ovf_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
        drive(1'b1, 32'h3F800000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b0, 1'b0, 12'd0, 13'd1, 32'h0}) begin
            mismatched++;
            $display("FAIL ovf_next_a: got %h want %h", obs_a, {1'b1, 1'b0, 1'b0, 12'd0, 13'd1, 32'h0});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd0, 5'd1, 32'h3F800000}) begin
            mismatched++;
            $display("FAIL ovf_next_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd0, 5'd1, 32'h3F800000});
        end
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b1, 32'h42000000, 1'b0);
        drive(1'b1, 32'h42000000, 1'b0);
        drive(1'b1, 32'h42000000, 1'b0);
        rst_n = 1'b0;
        #2;
        compared++;
        if (obs_a !== 60'd0) begin
            mismatched++;
            $display("FAIL midrst_zero_a: got %h want %h", obs_a, 60'd0);
        end
        compared++;
        if (obs_b !== 44'd0) begin
            mismatched++;
            $display("FAIL midrst_zero_b: got %h want %h", obs_b, 44'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h3F800000, 1'b0);
        drive(1'b1, 32'h40000000, 1'b1);
        compared++;
        if (obs_a !== {1'b1, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL midrst_res_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b0, 12'd1, 13'd2, 32'h40000000});
        end
        compared++;
        if (obs_b !== {1'b1, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000}) begin
            mismatched++;
            $display("FAIL midrst_res_b: got %h want %h", obs_b, {1'b1, 1'b1, 1'b0, 4'd1, 5'd2, 32'h40000000});
        end
`ifdef PEAK_NEIGHBOURS_EN
        compared++;
        if ({a_left, a_right, b_left, b_right} !== {32'h3F800000, 32'h0, 32'h3F800000, 32'h0}) begin
            mismatched++;
            $display("FAIL midrst_nb: got %h %h %h %h", a_left, a_right, b_left, b_right);
        end
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_dc_skip();
        test_tie();
        test_nan_negative();
        test_empty_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
